adc_sram_recorder: RTL

//  Capture path for the game audio: takes stereo ADC samples from audio_interface (adc_full/ADCDATA)
//  and writes them into the external 16-bit async SRAM as interleaved L,R words, starting at BASE_ADDR.

---
 rtl/adc_sram_recorder_pkg.sv | 32 +++
 rtl/adc_sram_recorder_write_port.sv | 95 +++++++++
 rtl/adc_sram_recorder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/adc_sram_recorder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_sram_recorder_pkg : shared types for the ADC-to-SRAM capture path
// Revision 1.0
// ---------------------------------------------------------------------------
package adc_sram_recorder_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ARM         = 3'd1,
    ST_WAIT_SAMPLE = 3'd2,
    ST_L_SETUP     = 3'd3,
    ST_L_WE        = 3'd4,
    ST_R_SETUP     = 3'd5,
    ST_R_WE        = 3'd6,
    ST_FINISH      = 3'd7
  } rec_state_t;

  typedef struct packed {
    logic [SRAM_DW-1:0] l;
    logic [SRAM_DW-1:0] r;
  } sample_t;

  function automatic logic is_writing(input rec_state_t s);
    return (s == ST_L_SETUP) || (s == ST_L_WE) || (s == ST_R_SETUP) || (s == ST_R_WE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sram_recorder_write_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_sram_recorder_write_port : one SRAM word write (setup + WE pulse), owns DQ tri-state
// Revision 1.0
// ---------------------------------------------------------------------------
module adc_sram_recorder_write_port
  import adc_sram_recorder_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] RESET_ADDR = 20'h00000,
  parameter int                 WE_CYCLES  = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               req,
  input  logic [SRAM_AW-1:0] addr,
  input  logic [SRAM_DW-1:0] data,
  output logic               ack,
  inout  wire  [SRAM_DW-1:0] sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               ce_n,
  output logic               we_n,
  output logic               oe_n,
  output logic               ub_n,
  output logic               lb_n
);

  localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WE_CYCLES - 1);

  typedef enum logic [1:0] {
    WP_IDLE  = 2'd0,
    WP_SETUP = 2'd1,
    WP_WE    = 2'd2
  } wp_phase_t;

  wp_phase_t          phase, phase_next;
  logic               load;
  logic [CW-1:0]      cnt;
  logic [SRAM_DW-1:0] dq_out;
  logic               dq_drive;

  always_ff @(posedge CLK) begin
    if (RESET) phase <= WP_IDLE;
    else       phase <= phase_next;
  end

  // ack is decoded from registers only, so a new request can chain on the last WE cycle
  always_comb begin
    phase_next = phase;
    load       = 1'b0;
    ack        = (phase == WP_WE) && (cnt == LAST_CNT);
    case (phase)
      WP_IDLE:  if (req) begin phase_next = WP_SETUP; load = 1'b1; end
      WP_SETUP: phase_next = WP_WE;
      WP_WE: begin
        if (ack) begin
          if (req) begin phase_next = WP_SETUP; load = 1'b1; end
          else           phase_next = WP_IDLE;
        end
      end
      default:  phase_next = WP_IDLE;
    endcase
  end

  // Pins are a registered decode of the next phase, so they change only on CLK
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt       <= '0;
      sram_addr <= RESET_ADDR;
      dq_out    <= '0;
      dq_drive  <= 1'b0;
      ce_n      <= 1'b1;
      we_n      <= 1'b1;
      ub_n      <= 1'b1;
      lb_n      <= 1'b1;
    end else begin
      if (phase == WP_WE) cnt <= cnt + 1'b1;
      else                cnt <= '0;
      if (load) begin
        sram_addr <= addr;
        dq_out    <= data;
      end
      dq_drive <= (phase_next != WP_IDLE);
      ce_n     <= (phase_next == WP_IDLE);
      ub_n     <= (phase_next == WP_IDLE);
      lb_n     <= (phase_next == WP_IDLE);
      we_n     <= (phase_next != WP_WE);
    end
  end

  assign oe_n    = 1'b1;
  assign sram_dq = dq_drive ? dq_out : {SRAM_DW{1'bz}};

endmodule
`default_nettype wire

// File: rtl/adc_sram_recorder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_sram_recorder : records stereo ADC samples into async SRAM as interleaved L,R words
// Revision 1.0
// ---------------------------------------------------------------------------
module adc_sram_recorder
  import adc_sram_recorder_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] BASE_ADDR = 20'h00000,
  parameter logic [SRAM_AW-1:0] LAST_ADDR = 20'hFFFFF,
  parameter int                 WE_CYCLES = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               STOP,
  input  logic               adc_full,
  input  logic [31:0]        ADCDATA,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               REC_BUSY,
  output logic               REC_DONE,
  output logic               OVERRUN,
  output logic [SRAM_AW-1:0] END_ADDR
);

  rec_state_t         state, state_next;
  logic               adc_prev;
  logic               sample_edge;
  logic               sample_valid;
  sample_t            hold;
  logic [SRAM_AW-1:0] addr_q;
  logic               stop_seen;
  logic               busy, done, overrun;
  logic               wp_req, wp_ack;
  logic [SRAM_AW-1:0] wp_addr;
  logic [SRAM_DW-1:0] wp_data;

  assign sample_edge = adc_full & ~adc_prev;

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    wp_req     = 1'b0;
    wp_addr    = addr_q;
    wp_data    = hold.l;
    case (state)
      ST_IDLE:        if (START) state_next = ST_ARM;
      ST_ARM:         state_next = ST_WAIT_SAMPLE;
      ST_WAIT_SAMPLE: begin
        if (STOP || stop_seen) state_next = ST_FINISH;
        else if (sample_valid) begin
          wp_req     = 1'b1;
          state_next = ST_L_SETUP;
        end
      end
      ST_L_SETUP:     state_next = ST_L_WE;
      ST_L_WE: begin
        if (wp_ack) begin
          if (addr_q == LAST_ADDR) state_next = ST_FINISH;
          else begin
            wp_req     = 1'b1;
            wp_addr    = addr_q + 1'b1;
            wp_data    = hold.r;
            state_next = ST_R_SETUP;
          end
        end
      end
      ST_R_SETUP:     state_next = ST_R_WE;
      ST_R_WE: begin
        if (wp_ack) begin
          if (STOP || stop_seen || (addr_q == LAST_ADDR)) state_next = ST_FINISH;
          else                                            state_next = ST_WAIT_SAMPLE;
        end
      end
      ST_FINISH:      state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  // Samples are taken only while waiting; edges during a pair are dropped and flagged
  always_ff @(posedge CLK) begin
    if (RESET) begin
      adc_prev     <= 1'b0;
      sample_valid <= 1'b0;
      hold         <= '0;
      addr_q       <= BASE_ADDR;
      stop_seen    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      adc_prev     <= adc_full;
      sample_valid <= sample_edge && (state == ST_WAIT_SAMPLE);
      if (sample_edge && (state == ST_WAIT_SAMPLE)) hold <= sample_t'(ADCDATA);
      if (sample_edge && is_writing(state))         overrun <= 1'b1;
      if (STOP && (state != ST_IDLE) && (state != ST_FINISH)) stop_seen <= 1'b1;
      if (((state == ST_L_WE) || (state == ST_R_WE)) && wp_ack) addr_q <= addr_q + 1'b1;
      if ((state == ST_IDLE) && START) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        overrun   <= 1'b0;
        stop_seen <= 1'b0;
        addr_q    <= BASE_ADDR;
      end
      if (state == ST_FINISH) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  adc_sram_recorder_write_port #(
    .RESET_ADDR (BASE_ADDR),
    .WE_CYCLES  (WE_CYCLES)
  ) u_write_port (
    .CLK       (CLK),
    .RESET     (RESET),
    .req       (wp_req),
    .addr      (wp_addr),
    .data      (wp_data),
    .ack       (wp_ack),
    .sram_dq   (SRAM_DQ),
    .sram_addr (SRAM_ADDR),
    .ce_n      (SRAM_CE_N),
    .we_n      (SRAM_WE_N),
    .oe_n      (SRAM_OE_N),
    .ub_n      (SRAM_UB_N),
    .lb_n      (SRAM_LB_N)
  );

  assign REC_BUSY = busy;
  assign REC_DONE = done;
  assign OVERRUN  = overrun;
  assign END_ADDR = addr_q;

endmodule
`default_nettype wire
